spi_slave_gen: RTL and testbench

Parametrised, oversampled SPI slave for register access, clocked entirely by the system clock `clk`. It supports all four CPOL/CPHA modes, a configurable address and data width, and multi-word burst frames. It decodes a command byte, an address field and data words, and drives a simple single-cycle register-bus master port toward the register file. It sits between the external SPI pins and the block register bank.

---
 rtl/spi_slv_pkg.sv | 22 ++
 rtl/spi_slv_sync_edge.sv | 38 +++
 rtl/spi_slave_gen.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared command codes, FSM state type and sizing helper for the oversampled SPI register slave.
package spi_slv_pkg;

  localparam logic [7:0] SPI_CMD_WR = 8'h3C;
  localparam logic [7:0] SPI_CMD_RD = 8'h5B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } spi_slv_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_slv_sync_edge.sv
// Multi-lane 2-flop synchroniser; the low EDGE_W lanes also get a third flop for rise/fall detection.
module spi_slv_sync_edge #(
  parameter int             W       = 1,
  parameter int             EDGE_W  = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      level,
  output logic [EDGE_W-1:0] rise,
  output logic [EDGE_W-1:0] fall
);

  logic [W-1:0]      meta_reg;
  logic [W-1:0]      sync_reg;
  logic [EDGE_W-1:0] dly_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
      dly_reg  <= RST_VAL[EDGE_W-1:0];
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg[EDGE_W-1:0];
    end
  end

  assign level = sync_reg;

  for (genvar gi = 0; gi < EDGE_W; gi++) begin : g_edge
    assign rise[gi] = sync_reg[gi] & ~dly_reg[gi];
    assign fall[gi] = ~sync_reg[gi] & dly_reg[gi];
  end

endmodule

// File: rtl/spi_slave_gen.sv
// Oversampled SPI slave driving a single-cycle register bus; all four CPOL/CPHA modes, burst frames.
// Define SPI_SLV_ADDR_INC_EN to auto-increment reg_addr per burst word (otherwise FIFO-port style).
module spi_slave_gen
  import spi_slv_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csn,
  input  logic          sclk,
  input  logic          mosi,
  output logic          miso,
  output logic          reg_wr,
  output logic          reg_rd,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          frame_err
);

  localparam int   MW         = max3(AW, DW, 8);
  localparam int   CW         = $clog2(MW) + 1;
  localparam logic SAMPLE_LVL = (CPOL == CPHA);
`ifdef SPI_SLV_ADDR_INC_EN
  localparam logic ADDR_INC = 1'b1;
`else
  localparam logic ADDR_INC = 1'b0;
`endif

  // csn lane resets low so a frame cut by reset is ignored until csn rises and falls again
  logic [2:0] lvl;
  logic [1:0] rise, fall;

  spi_slv_sync_edge #(
    .W      (3),
    .EDGE_W (2),
    .RST_VAL({2'b00, 1'(CPOL)})
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({mosi, csn, sclk}),
    .level(lvl),
    .rise (rise),
    .fall (fall)
  );

  logic sclk_edge, sample, drive, csn_s, mosi_s;
  assign sclk_edge = rise[0] | fall[0];
  assign sample    = sclk_edge && (lvl[0] == SAMPLE_LVL);
  assign drive     = sclk_edge && (lvl[0] != SAMPLE_LVL);
  assign csn_s     = lvl[1];
  assign mosi_s    = lvl[2];

  spi_slv_state_t state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [MW-2:0]  rx_reg;
  logic [DW-1:0]  tx_reg;
  logic           load_reg;
  logic           cmd_rd_reg;

  logic [CW-1:0]  field_len;
  logic [MW-1:0]  rx_next;
  logic           in_field;
  logic           last_bit;

  always_comb begin
    field_len  = CW'(8);
    state_next = state_reg;
    rx_next    = {rx_reg, mosi_s};
    in_field   = state_reg inside {ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA};
    case (state_reg)
      ST_ADDR:            field_len = CW'(AW);
      ST_WDATA, ST_RDATA: field_len = CW'(DW);
      default:            field_len = CW'(8);
    endcase
    last_bit = sample && in_field && (cnt_reg == field_len - CW'(1));
    case (state_reg)
      ST_IDLE: if (csn_fall_ok()) state_next = ST_CMD;
      ST_CMD:
        if (last_bit)
          state_next = (rx_next[7:0] == SPI_CMD_WR || rx_next[7:0] == SPI_CMD_RD) ? ST_ADDR : ST_IGNORE;
      ST_ADDR: if (last_bit) state_next = cmd_rd_reg ? ST_RDATA : ST_WDATA;
      default: state_next = state_reg;
    endcase
    if (csn_s) state_next = ST_IDLE;
  end

  function automatic logic csn_fall_ok();
    return fall[1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      rx_reg     <= '0;
      tx_reg     <= '0;
      load_reg   <= 1'b0;
      cmd_rd_reg <= 1'b0;
      miso       <= 1'b1;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      load_reg  <= reg_rd;
      if (ADDR_INC && reg_wr) reg_addr <= reg_addr + 1'b1;
      if (csn_s) begin
        cnt_reg   <= '0;
        miso      <= 1'b1;
        frame_err <= rise[1] && in_field && (cnt_reg != '0);
      end else begin
        if (sample && in_field) begin
          rx_reg  <= rx_next[MW-2:0];
          cnt_reg <= last_bit ? '0 : cnt_reg + CW'(1);
        end
        if (last_bit) begin
          case (state_reg)
            ST_CMD:  cmd_rd_reg <= (rx_next[7:0] == SPI_CMD_RD);
            ST_ADDR: begin
              reg_addr <= rx_next[AW-1:0];
              reg_rd   <= cmd_rd_reg;
            end
            ST_WDATA: begin
              reg_wr    <= 1'b1;
              reg_wdata <= rx_next[DW-1:0];
            end
            ST_RDATA: begin
              reg_rd <= 1'b1;
              if (ADDR_INC) reg_addr <= reg_addr + 1'b1;
            end
            default: ;
          endcase
        end
        if (state_reg == ST_RDATA) begin
          if (drive) begin
            miso   <= tx_reg[DW-1];
            tx_reg <= {tx_reg[DW-2:0], 1'b0};
          end
        end else begin
          miso <= 1'b1;
        end
      end
      // read data arrives one cycle after reg_rd; it always lands before the next drive edge
      if (load_reg) tx_reg <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboard bench: one DUT per SPI mode on a shared bus, the monitored instance selected per frame.
module tb_spi_slave_gen;

  localparam int NM = 4;
`ifdef SPI_SLV_ADDR_INC_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, csn = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso_v[NM], wr_v[NM], rd_v[NM], ferr_v[NM];
  logic [7:0]  addr_v[NM];
  logic [15:0] wdata_v[NM];
  logic [15:0] mem[256];

  int total = 0, bad = 0;
  int cur = 0;
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_err_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NM; gi++) begin : g_dut
    localparam int DWI = (gi == 0) ? 8 : 16;
    logic [DWI-1:0] wd;
    logic [DWI-1:0] rdt;
    spi_slave_gen #(.AW(8), .DW(DWI), .CPOL(gi / 2), .CPHA(gi % 2)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .csn      (csn),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso_v[gi]),
      .reg_wr   (wr_v[gi]),
      .reg_rd   (rd_v[gi]),
      .reg_addr (addr_v[gi]),
      .reg_wdata(wd),
      .reg_rdata(rdt),
      .frame_err(ferr_v[gi])
    );
    assign wdata_v[gi] = 16'(wd);
    always @(posedge clk) if (rd_v[gi]) rdt <= mem[addr_v[gi]][DWI-1:0];
  end

  logic        miso_c, wr_c, rd_c, ferr_c;
  logic [7:0]  addr_c;
  logic [15:0] wdata_c;
  assign miso_c  = miso_v[cur];
  assign wr_c    = wr_v[cur];
  assign rd_c    = rd_v[cur];
  assign ferr_c  = ferr_v[cur];
  assign addr_c  = addr_v[cur];
  assign wdata_c = wdata_v[cur];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // register-bus monitor
  always @(negedge clk) begin
    if (wr_c) begin
      if (exp_wr_q.size() == 0) check("unexpected_reg_wr", {addr_c, wdata_c}, 24'hxxxxxx);
      else check("reg_wr_addr_data", {addr_c, wdata_c}, exp_wr_q.pop_front());
    end
    if (wr_c && rd_c) check("wr_rd_overlap", 32'(rd_c), 32'd0);
    if (ferr_c) begin
      if (exp_err_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
      else void'(exp_err_q.pop_front());
      if (exp_err_q.size() >= 0) total++;
    end
  end

  // SPI-pin monitor: decodes the frame from mosi and collects miso words at the sample edges
  int         mbit = 0, mwbits = 0;
  logic [7:0] mcmd = 8'h00;
  logic [15:0] mword = 16'h0;
  bit         miso_bad = 1'b0;
  logic       csn_prev = 1'b1, sclk_prev = 1'b0;

  always @(sclk or csn) begin
    if (csn && !csn_prev && mbit > 0) begin
      check("miso_idle_high", 32'(miso_bad), 32'd0);
      mbit = 0; mwbits = 0; miso_bad = 1'b0;
    end
    if (!csn && sclk != sclk_prev && sclk == ((cur / 2) == (cur % 2))) begin
      mbit++;
      if (mbit <= 8) mcmd = {mcmd[6:0], mosi};
      else if (mbit > 16 && mcmd == 8'h5B) begin
        mword = {mword[14:0], miso_c};
        mwbits++;
        if (mwbits == ((cur == 0) ? 8 : 16)) begin
          mwbits = 0;
          if (exp_rd_q.size() == 0) check("unexpected_read_word", 32'(mword), 32'hxxxx);
          else check("miso_word", 32'(mword), 32'(exp_rd_q.pop_front()));
          mword = 16'h0;
        end
      end else if (miso_c !== 1'b1) miso_bad = 1'b1;
    end
    csn_prev  = csn;
    sclk_prev = sclk;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int m, input logic [7:0] cmd, input logic [7:0] addr, input int nw,
                       input logic [15:0] w0, input int abort_bits, input int rst_bit);
    int dw;
    logic [15:0] mask, w;
    logic [7:0] a;
    bit bits[$];
    dw   = (m == 0) ? 8 : 16;
    mask = (m == 0) ? 16'h00FF : 16'hFFFF;
    cur  = m;
    sclk = 1'((m / 2));
    clk_wait(6);
    for (int i = 7; i >= 0; i--) bits.push_back(cmd[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(addr[i]);
    for (int k = 0; k < nw; k++) begin
      w = ((k == 0) ? w0 : 16'($urandom)) & mask;
      for (int i = dw - 1; i >= 0; i--) bits.push_back(w[i]);
      a = INC ? 8'(addr + 8'(k)) : addr;
      if (rst_bit < 0) begin
        if (cmd == 8'h3C) exp_wr_q.push_back({a, w});
        else if (cmd == 8'h5B) exp_rd_q.push_back(mem[a] & mask);
      end
    end
    for (int i = 0; i < abort_bits; i++) bits.push_back(1'($urandom_range(0, 1)));
    if (abort_bits > 0 && rst_bit < 0 && (cmd == 8'h3C || cmd == 8'h5B)) exp_err_q.push_back(1);
    csn = 1'b0;
    clk_wait(4);
    for (int i = 0; i < bits.size(); i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        clk_wait(2);
        rst_n = 1'b1;
      end
      if (m % 2 == 0) begin
        mosi = bits[i]; clk_wait(4); sclk = ~sclk; clk_wait(4); sclk = ~sclk;
      end else begin
        sclk = ~sclk; mosi = bits[i]; clk_wait(4); sclk = ~sclk; clk_wait(4);
      end
    end
    clk_wait(4);
    csn = 1'b1;
    clk_wait(8);
  endtask

  initial begin
    int m, r, nw, ab;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h20] = 16'hBEEF;
    clk_wait(5);
    for (int i = 0; i < NM; i++) begin
      cur = i;
      #1;
      check("rst_miso", 32'(miso_c), 32'd1);
      check("rst_reg_wr", 32'(wr_c), 32'd0);
      check("rst_reg_rd", 32'(rd_c), 32'd0);
      check("rst_frame_err", 32'(ferr_c), 32'd0);
      check("rst_reg_addr", 32'(addr_c), 32'd0);
      check("rst_reg_wdata", 32'(wdata_c), 32'd0);
    end
    rst_n = 1'b1;
    clk_wait(5);

    frame(0, 8'h3C, 8'h10, 1, 16'h00A5, 0, -1);
    frame(0, 8'h77, 8'h33, 2, 16'h1234, 0, -1);
    frame(0, 8'h3C, 8'h40, 0, 16'h0000, 4, -1);
    frame(3, 8'h5B, 8'h20, 1, 16'h0000, 0, -1);
    frame(3, 8'h3C, 8'hFF, 3, 16'($urandom), 0, -1);
    frame(1, 8'h3C, 8'h55, 2, 16'hCAFE, 0, 20);
    frame(1, 8'h3C, 8'h56, 1, 16'h7E57, 0, -1);

    for (int k = 0; k < 16; k++) begin
      m  = (k < 6) ? 1 : (k < 12) ? 2 : k % 4;
      r  = $urandom_range(0, 2);
      c  = 8'($urandom);
      if (c == 8'h3C || c == 8'h5B) c = 8'h00;
      c  = (r == 0) ? 8'h3C : (r == 1) ? 8'h5B : c;
      nw = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (m == 0) ? 7 : 15) : 0;
      frame(m, c, 8'($urandom), nw, 16'($urandom), ab, -1);
    end

    clk_wait(20);
    check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_reads", 32'(exp_rd_q.size()), 32'd0);
    check("pending_frame_err", 32'(exp_err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
